pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Sequences the 5-stage pipeline by turning four stall/redirect requests into per-register write enables, flushes and bubble inserts. The requests are load-use/branch-operand hazard, taken branch resolved in ID, I-cache miss and D-cache miss. It sits between the hazard detection unit, the ID-stage branch comparator, both caches, and the PC and pipeline registers. A one-deep pending-redirect state handles a taken branch that resolves while the I-cache is mid-fetch. Saturating counters for stall cycles and redirects support performance debug.

## Interface
- CNT_W, 32, width of both performance counters
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- HazardStall  in  1  from hazard detection unit: ID instruction must hold
- BranchTaken  in  1  ID-stage branch/jump resolved taken this cycle
- ICacheStall  in  1  I-cache fetch not complete
- DCacheStall  in  1  D-cache access not complete
- PcWrite  out  1  PC register load enable
- UseHeldTarget  out  1  PC mux selects the held redirect target instead of the live branch target
- TargetCapture  out  1  PC unit latches the live branch target into its hold register
- IfIdWrite  out  1  IF/ID load enable
- IfIdFlush  out  1  IF/ID loads NOP; overrides IfIdWrite
- IdExBubble  out  1  ID/EX loads NOP control word
- ExMemWrite, MemWbWrite  out  1 each  back-end register load enables
- Pending  out  1  state == PEND
- StallCycles  out  CNT_W  cycles with PcWrite=0, saturating
- RedirectCount  out  CNT_W  accepted taken branches, saturating

## Operation
- States: RUN, PEND. Only state register, Pending, and counters are sequential. All other outputs are combinational from state and inputs.
- Evaluate the following priority in order. Unlisted outputs are 0; write enables default to 1 where not stated.
- 1. DCacheStall=1, any state: every write enable 0, IfIdFlush/IdExBubble/TargetCapture/UseHeldTarget 0. Ignore BranchTaken. Hold state.
- 2. RUN, HazardStall=1: PcWrite=0, IfIdWrite=0, IdExBubble=1, back-end 1. Ignore BranchTaken and ICacheStall.
- 3. RUN, ICacheStall=1, BranchTaken=0: PcWrite=0, IfIdFlush=1, back-end 1.
- 4. RUN, ICacheStall=1, BranchTaken=1: PcWrite=0, IfIdFlush=1, TargetCapture=1. Next state PEND. Count redirect.
- 5. RUN, BranchTaken=1: PcWrite=1, UseHeldTarget=0, IfIdFlush=1. Count redirect.
- 6. RUN, otherwise: all writes 1.
- 7. PEND, ICacheStall=1: PcWrite=0, IfIdFlush=1, back-end 1.
- 8. PEND, ICacheStall=0: wrong-path fetch completes and is discarded. PcWrite=1, UseHeldTarget=1, IfIdFlush=1. Next state RUN.
- In PEND, ignore BranchTaken and HazardStall. ID holds a NOP, so neither can be legitimately asserted.
- I-cache holds its completed output while PcWrite=0. This covers PEND with ICacheStall=0 and DCacheStall=1, which freezes in PEND.
- Counters:
  - StallCycles += 1 each cycle PcWrite=0, rst deasserted.
  - RedirectCount += 1 on cases 4 and 5.
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Control outputs are same-cycle combinational, with zero latency from inputs.
- State and counters update on the rising clk edge after the qualifying cycle.
- Redirect during I-miss:
  - TargetCapture is a 1-cycle pulse.
  - UseHeldTarget is asserted exactly one non-frozen cycle, the first with ICacheStall=0 and DCacheStall=0 after capture.
  - Minimum capture-to-apply gap is 1 cycle.
- rst=1, asynchronous:
  - State goes to RUN; counters go to 0.
  - Every control output is forced 0 while rst=1, including PcWrite and all write enables.
  - Reset mid-PEND discards the held redirect.
- Simultaneous DCacheStall and ICacheStall: case 1 wins. I-side handling resumes the cycle DCacheStall drops.

## Test plan
- Load-use: RUN, HazardStall=1 for 1 cycle -> PcWrite=0, IfIdWrite=0, IdExBubble=1, ExMemWrite=1; StallCycles 0->1.
- Taken branch, no miss: BranchTaken=1 -> PcWrite=1, IfIdFlush=1, UseHeldTarget=0; RedirectCount=1; state stays RUN.
- Branch during I-miss:
  - Stimulus: ICacheStall=1 cycles 0-3, BranchTaken=1 cycle 1.
  - Required: TargetCapture only cycle 1; Pending=1 after edge 1; cycle 4 PcWrite=1, UseHeldTarget=1, IfIdFlush=1; Pending=0 after edge 4; StallCycles=4.
- D-miss freeze in PEND: enter PEND, then ICacheStall=0, DCacheStall=1 for 3 cycles -> all enables 0, UseHeldTarget=0, Pending stays 1; first cycle after DCacheStall drops gives UseHeldTarget=1.
- Saturation: CNT_W=4, HazardStall held 20 cycles -> StallCycles stops at 15.
- Async reset: assert rst mid-PEND between clock edges -> Pending, counters, PcWrite immediately 0; after release, ICacheStall=0 -> no UseHeldTarget.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Turns hazard, taken-branch and cache-miss requests into PC/pipeline register controls.
// A one-deep PEND state defers a taken branch that resolves while the I-cache is missing.
module pipeline_stall_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             HazardStall,
    input  logic             BranchTaken,
    input  logic             ICacheStall,
    input  logic             DCacheStall,
    output logic             PcWrite,
    output logic             UseHeldTarget,
    output logic             TargetCapture,
    output logic             IfIdWrite,
    output logic             IfIdFlush,
    output logic             IdExBubble,
    output logic             ExMemWrite,
    output logic             MemWbWrite,
    output logic             Pending,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] RedirectCount
);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic             redirect;

    always_comb begin
        state_d       = state_q;
        redirect      = 1'b0;
        PcWrite       = 1'b1;
        IfIdWrite     = 1'b1;
        ExMemWrite    = 1'b1;
        MemWbWrite    = 1'b1;
        UseHeldTarget = 1'b0;
        TargetCapture = 1'b0;
        IfIdFlush     = 1'b0;
        IdExBubble    = 1'b0;
        if (rst || DCacheStall) begin
            // D-miss freezes the whole pipe; reset forces every control low.
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            ExMemWrite = 1'b0;
            MemWbWrite = 1'b0;
        end else if (state_q == RUN) begin
            if (HazardStall) begin
                PcWrite    = 1'b0;
                IfIdWrite  = 1'b0;
                IdExBubble = 1'b1;
            end else if (ICacheStall) begin
                PcWrite   = 1'b0;
                IfIdFlush = 1'b1;
                if (BranchTaken) begin
                    TargetCapture = 1'b1;
                    state_d       = PEND;
                    redirect      = 1'b1;
                end
            end else if (BranchTaken) begin
                IfIdFlush = 1'b1;
                redirect  = 1'b1;
            end
        end else begin
            // The wrong-path fetch in flight is always discarded.
            IfIdFlush = 1'b1;
            if (ICacheStall) begin
                PcWrite = 1'b0;
            end else begin
                UseHeldTarget = 1'b1;
                state_d       = RUN;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (!rst && !PcWrite && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (redirect && redir_cnt_q != CNT_MAX)
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign Pending       = (state_q == PEND);
    assign StallCycles   = stall_cnt_q;
    assign RedirectCount = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: a driver pushes model predictions per cycle, a negedge monitor compares.
// Two instances (32-bit and 4-bit counters) share stimulus so saturation is exercised.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst, hz, br, ic, dc;

    logic        pc_w, uht, tcap, ifid_w, ifid_f, idex_b, exm_w, mwb_w, pend;
    logic [31:0] sc, rc;
    logic        pc_w4, uht4, tcap4, ifid_w4, ifid_f4, idex_b4, exm_w4, mwb_w4, pend4;
    logic [3:0]  sc4, rc4;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .HazardStall(hz), .BranchTaken(br),
        .ICacheStall(ic), .DCacheStall(dc),
        .PcWrite(pc_w), .UseHeldTarget(uht), .TargetCapture(tcap),
        .IfIdWrite(ifid_w), .IfIdFlush(ifid_f), .IdExBubble(idex_b),
        .ExMemWrite(exm_w), .MemWbWrite(mwb_w), .Pending(pend),
        .StallCycles(sc), .RedirectCount(rc)
    );

    pipeline_stall_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .HazardStall(hz), .BranchTaken(br),
        .ICacheStall(ic), .DCacheStall(dc),
        .PcWrite(pc_w4), .UseHeldTarget(uht4), .TargetCapture(tcap4),
        .IfIdWrite(ifid_w4), .IfIdFlush(ifid_f4), .IdExBubble(idex_b4),
        .ExMemWrite(exm_w4), .MemWbWrite(mwb_w4), .Pending(pend4),
        .StallCycles(sc4), .RedirectCount(rc4)
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic        pend;
        logic [31:0] sc;
        logic [31:0] rc;
        logic [3:0]  sc4;
        logic [3:0]  rc4;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done = 0;

    // Reference model: a held-redirect flag plus two unbounded-then-clamped counters.
    bit     held;
    longint m_sc, m_rc;
    bit     nx_held;
    longint nx_sc, nx_rc;

    // Control word order: {PcWrite, UseHeldTarget, TargetCapture, IfIdWrite,
    //                      IfIdFlush, IdExBubble, ExMemWrite, MemWbWrite}
    function automatic logic [7:0] ctrl_of(int c);
        case (c)
            2:       return 8'b0000_0111;
            3, 7:    return 8'b0001_1011;
            4:       return 8'b0011_1011;
            5:       return 8'b1001_1011;
            6:       return 8'b1001_0011;
            8:       return 8'b1101_1011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic int case_of(bit h, bit b, bit i, bit d, bit p);
        if (d)  return 1;
        if (p)  return i ? 7 : 8;
        if (h)  return 2;
        if (i)  return b ? 4 : 3;
        if (b)  return 5;
        return 6;
    endfunction

    function automatic longint sat_inc(longint v, longint cap);
        return (v < cap) ? v + 1 : v;
    endfunction

    task automatic step(bit r, bit h, bit b, bit i, bit d);
        exp_t e;
        int   c;
        @(posedge clk);
        #1;
        held = nx_held; m_sc = nx_sc; m_rc = nx_rc;
        rst = r; hz = h; br = b; ic = i; dc = d;
        if (r) begin
            held = 0; m_sc = 0; m_rc = 0;
            e.ctrl = 8'h00;
            nx_held = 0; nx_sc = 0; nx_rc = 0;
        end else begin
            c = case_of(h, b, i, d, held);
            e.ctrl = ctrl_of(c);
            nx_held = (c == 4) ? 1'b1 : (c == 8) ? 1'b0 : held;
            nx_sc   = e.ctrl[7] ? m_sc : m_sc + 1;
            nx_rc   = (c == 4 || c == 5) ? m_rc + 1 : m_rc;
        end
        e.pend = held;
        e.sc   = 32'(m_sc > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_sc);
        e.rc   = 32'(m_rc > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_rc);
        e.sc4  = 4'(m_sc > 15 ? 15 : m_sc);
        e.rc4  = 4'(m_rc > 15 ? 15 : m_rc);
        q.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (q.size() == 0) continue;
            e = q.pop_front();
            chk("ctrl",    {24'd0, pc_w, uht, tcap, ifid_w, ifid_f, idex_b, exm_w, mwb_w}, {24'd0, e.ctrl});
            chk("ctrl4",   {24'd0, pc_w4, uht4, tcap4, ifid_w4, ifid_f4, idex_b4, exm_w4, mwb_w4}, {24'd0, e.ctrl});
            chk("pending", {31'd0, pend}, {31'd0, e.pend});
            chk("pending4",{31'd0, pend4}, {31'd0, e.pend});
            chk("stall",   sc, e.sc);
            chk("redir",   rc, e.rc);
            chk("stall4",  {28'd0, sc4}, {28'd0, e.sc4});
            chk("redir4",  {28'd0, rc4}, {28'd0, e.rc4});
        end
    end

    initial begin
        rst = 1; hz = 0; br = 0; ic = 0; dc = 0;
        held = 0; m_sc = 0; m_rc = 0; nx_held = 0; nx_sc = 0; nx_rc = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // load-use, then taken branch without a miss
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // branch during I-miss: capture in cycle 1, apply in cycle 4
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // D-miss freeze while pending, with simultaneous I-miss first
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // hazard held 20 cycles saturates the 4-bit stall counter
        for (int k = 0; k < 20; k++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // reset mid-PEND discards the held redirect
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // enough taken branches to saturate the 4-bit redirect counter
        for (int k = 0; k < 18; k++) step(0, 0, 1, 0, 0);
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1;
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
